// File: rtl/uart_pkg.sv
// uart_pkg: shared byte width and drain FSM state type for the UART transmit path
package uart_pkg;
  localparam int UART_BYTE_W = 8;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} drain_state_t;
endpackage

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO with flush and registered level/empty/full
// ports: clk/rst; push+push_data write; pop consumes head (valid while !empty);
//        flush discards all contents; level/empty/full describe the state after each edge
module uart_byte_fifo import uart_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_BYTE_W-1:0] push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [UART_BYTE_W-1:0] head,
  output logic [LW-1:0]          level,
  output logic                   empty,
  output logic                   full
);
  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic do_push, do_pop;
  logic [LW-1:0] nxt_level;
  always_comb begin
    do_push = push & ~full;
    do_pop = pop & ~empty;
    nxt_level = level + LW'(do_push) - LW'(do_pop);
  end
  assign head = mem[rptr];
  always_ff @(posedge clk) if (do_push) mem[wptr] <= push_data;
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      empty <= 1'b1;
      full <= 1'b0;
    end else begin
      wptr <= wptr + AW'(do_push);
      rptr <= rptr + AW'(do_pop);
      level <= nxt_level;
      empty <= nxt_level == '0;
      full <= nxt_level == LW'(DEPTH);
    end
  end
endmodule

// File: rtl/uart_tx_buf.sv
// uart_tx_buf: unpacks 1-4 byte bus words into a byte FIFO and drains it to the UART transmitter
// ports: clk_i/rst_i; wr_data_i/wr_len_i/wr_vld_i/wr_rdy_o word write; flush_i discards buffered data;
//        uart_tx_data_o/uart_tx_data_vld_o/uart_tx_data_rdy_i byte handshake; level_o/empty_o/full_o status
module uart_tx_buf import uart_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [31:0]            wr_data_i,
  input  logic [1:0]             wr_len_i,
  input  logic                   wr_vld_i,
  output logic                   wr_rdy_o,
  input  logic                   flush_i,
  output logic [UART_BYTE_W-1:0] uart_tx_data_o,
  output logic                   uart_tx_data_vld_o,
  input  logic                   uart_tx_data_rdy_i,
  output logic [LVL_W-1:0]       level_o,
  output logic                   empty_o,
  output logic                   full_o
);
  logic busy, pop;
  logic [31:0] word;
  logic [1:0] len, idx;
  logic [UART_BYTE_W-1:0] cur_byte, head;
  drain_state_t state;
  assign wr_rdy_o = ~busy;
  assign cur_byte = word[{idx, 3'b000} +: UART_BYTE_W];
  assign pop = (state == IDLE) & ~empty_o & uart_tx_data_rdy_i;
  uart_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(busy),
    .push_data(cur_byte),
    .pop(pop),
    .flush(flush_i),
    .head(head),
    .level(level_o),
    .empty(empty_o),
    .full(full_o)
  );
  // unpacker: one byte per non-full cycle, lowest byte first
  always_ff @(posedge clk_i) begin
    if (rst_i | flush_i) begin
      busy <= 1'b0;
      word <= '0;
      len <= '0;
      idx <= '0;
    end else if (!busy) begin
      busy <= wr_vld_i;
      if (wr_vld_i) begin
        word <= wr_data_i;
        len <= wr_len_i;
        idx <= '0;
      end
    end else if (!full_o) begin
      idx <= idx + 2'd1;
      busy <= idx != len;
    end
  end
  // drain FSM: strobe once, then wait for the transmitter to drop ready before the next pop
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      uart_tx_data_o <= '0;
      uart_tx_data_vld_o <= 1'b0;
    end else begin
      uart_tx_data_vld_o <= pop;
      if (pop) uart_tx_data_o <= head;
      state <= pop ? SEND : state == SEND ? WAIT : (state == WAIT && !uart_tx_data_rdy_i) ? IDLE : state;
    end
  end
endmodule
